hex_view_sel_ctrl: RTL and testbench
====================================

Name: hex_view_sel_ctrl

Overview:
- Generates the 3-bit view select that drives the 8:1 hex-display mux. It also registers the 16-bit mux output back for the hex decoders.
- Steps the view on a debounced pushbutton press, or cycles views automatically at a fixed period.
- A Freeze switch holds both the displayed value and the select, so the operator can read a value that is changing.
- Sits between the board buttons/switches and the display mux/hex decoder path.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); legal range 2 or more.
AUTO_PERIOD, 50000000, cycles between automatic view advances (1 s at 50 MHz); legal range 2 or more.
NUM_VIEWS, 8, number of selectable views; Sel wraps from NUM_VIEWS-1 to 0; legal range 2..8.

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-high reset
StepBtn  input  1  raw pushbutton, active-high, asynchronous to Clock, bouncy
AutoEn  input  1  slide switch, 1 = auto-cycle views; asynchronous
Freeze  input  1  slide switch, 1 = hold display and select; asynchronous
MuxIn  input  16  selected value returned from the display mux
Sel  output  3  view select to mux
DispOut  output  16  registered value to hex decoders
StepPulse  output  1  one-cycle strobe on each accepted button press

Behaviour:
- Interface (decided): one clock, Clock; reset Reset is asynchronous and active-high.
- Reset values: Sel=0, DispOut=0, StepPulse=0, debouncer state IDLE_LOW, debounce counter=0, prescaler=0, all synchronizer flops=0.
- Synchronization:
  - StepBtn, AutoEn and Freeze each pass through a 2-flop synchronizer.
  - Internal signals btn_s, auto_s, frz_s lag the pins by 2 cycles.
- Debouncer FSM (states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW):
  - IDLE_LOW: btn_s=1 -> WAIT_HIGH, counter cleared.
  - WAIT_HIGH:
    - btn_s=0 -> IDLE_LOW.
    - Otherwise the counter increments.
    - When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still 1 -> IDLE_HIGH, and StepPulse=1 for exactly that transition cycle.
  - IDLE_HIGH: btn_s=0 -> WAIT_LOW, counter cleared.
  - WAIT_LOW: btn_s=1 -> IDLE_HIGH; counter reaching DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE_LOW. No pulse on release.
  - Holding the button produces exactly one StepPulse. Bounces shorter than DEBOUNCE_CYCLES produce none.
- Auto prescaler:
  - Counts 0..AUTO_PERIOD-1 while auto_s=1 and frz_s=0.
  - Reaching AUTO_PERIOD-1 produces an auto tick and wraps to 0.
  - Forced to 0 while auto_s=0.
  - Also forced to 0 in any cycle with StepPulse=1, so the next auto advance comes a full period after a manual step.
  - Holds its value (no count) while frz_s=1.
- Sel update:
  - Increments by 1 in any cycle where (StepPulse or auto tick) and frz_s=0.
  - If StepPulse and an auto tick coincide, Sel advances exactly once.
  - Wrap: Sel=NUM_VIEWS-1 -> 0.
  - Sel changes on the clock edge after the triggering cycle.
- Freeze behaviour:
  - While frz_s=1, Sel does not change.
  - StepPulse is still generated, but the press is discarded, not queued.
- DispOut:
  - Loads MuxIn every cycle while frz_s=0, giving 1-cycle latency from MuxIn to DispOut.
  - Holds its value while frz_s=1.
  - The first cycle with frz_s=0 after a freeze reloads from MuxIn.
- Reset mid-operation: all state returns to reset values immediately. A button held through the release of Reset is treated as a new press once debounced.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
Use DEBOUNCE_CYCLES=4, AUTO_PERIOD=10, NUM_VIEWS=8 for all scenarios.
- Clean press: hold StepBtn high 20 cycles -> exactly one StepPulse, about 2+4 cycles after the rising edge; Sel 0->1; release gives no pulse and Sel stays 1.
- Bounce: toggle StepBtn 1,0,1,0 with 2-cycle widths, then hold 1 -> no pulse during the bounce, one pulse after 4 stable cycles, Sel=1.
- Wrap: 8 clean presses from reset -> Sel visits 1..7 then 0.
- Auto mode: AutoEn=1 for 35 cycles past synchronization -> Sel advances every 10 cycles to 3.
  - A manual press at prescaler=7 advances Sel once and restarts the 10-cycle interval.
  - A coincident tick and press advances Sel by 1, not 2.
- Freeze:
  - Drive MuxIn=16'h1234, then Freeze=1, then MuxIn=16'hBEEF -> DispOut stays 16'h1234; a press and auto ticks leave Sel unchanged.
  - Freeze=0 -> DispOut=16'hBEEF within 3 cycles.
- Async reset: assert Reset mid-WAIT_HIGH with Sel=5, DispOut=16'hABCD -> Sel=0, DispOut=0, StepPulse=0 immediately without a clock edge; no pulse after deassert until a fresh 4-cycle stable press.

Source files
------------

// File: rtl/hex_view_sel_ctrl.sv
// hex_view_sel_ctrl
//   Produces the 3-bit view select for the 8:1 hex-display mux and registers
//   the mux result back toward the hex decoders. The view advances on a
//   debounced pushbutton press, or automatically every AUTO_PERIOD cycles.
//   Freeze holds both the select and the displayed value.
//
// Ports
//   Clock      in   1   system clock
//   Reset      in   1   asynchronous, active-high reset
//   StepBtn    in   1   raw pushbutton (bouncy, asynchronous)
//   AutoEn     in   1   1 = auto-cycle views (asynchronous switch)
//   Freeze     in   1   1 = hold select and display (asynchronous switch)
//   MuxIn      in   16  value returned from the display mux
//   Sel        out  3   view select to the mux
//   DispOut    out  16  registered value to the hex decoders
//   StepPulse  out  1   one-cycle strobe per accepted button press
//
// Debouncer states
//   state     | meaning
//   IDLE_LOW  | button accepted as released
//   WAIT_HIGH | button seen high, counting stable high cycles
//   IDLE_HIGH | button accepted as pressed
//   WAIT_LOW  | button seen low, counting stable low cycles

module hex_view_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 50000000,
  parameter int NUM_VIEWS       = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        StepBtn,
  input  logic        AutoEn,
  input  logic        Freeze,
  input  logic [15:0] MuxIn,
  output logic [2:0]  Sel,
  output logic [15:0] DispOut,
  output logic        StepPulse
);

  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PSW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST  = PSW'(AUTO_PERIOD - 1);
  localparam logic [2:0]     SEL_LAST = 3'(NUM_VIEWS - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  logic [1:0] btn_sync;
  logic [1:0] auto_sync;
  logic [1:0] frz_sync;
  logic       btn_s;
  logic       auto_s;
  logic       frz_s;

  db_state_t      db_state;
  logic [DBW-1:0] db_cnt;
  logic [PSW-1:0] prescale;
  logic           auto_tick;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_sync  <= 2'b00;
      auto_sync <= 2'b00;
      frz_sync  <= 2'b00;
    end else begin
      btn_sync  <= {btn_sync[0], StepBtn};
      auto_sync <= {auto_sync[0], AutoEn};
      frz_sync  <= {frz_sync[0], Freeze};
    end
  end

  assign btn_s  = btn_sync[1];
  assign auto_s = auto_sync[1];
  assign frz_s  = frz_sync[1];

  // Debouncer; StepPulse is registered and rises only on WAIT_HIGH -> IDLE_HIGH.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      db_state  <= IDLE_LOW;
      db_cnt    <= '0;
      StepPulse <= 1'b0;
    end else begin
      StepPulse <= 1'b0;
      case (db_state)
        IDLE_LOW: begin
          if (btn_s) begin
            db_state <= WAIT_HIGH;
            db_cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!btn_s) begin
            db_state <= IDLE_LOW;
          end else if (db_cnt == DB_LAST) begin
            db_state  <= IDLE_HIGH;
            StepPulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!btn_s) begin
            db_state <= WAIT_LOW;
            db_cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (btn_s) begin
            db_state <= IDLE_HIGH;
          end else if (db_cnt == DB_LAST) begin
            db_state <= IDLE_LOW;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          db_state <= IDLE_LOW;
          db_cnt   <= '0;
        end
      endcase
    end
  end

  assign auto_tick = auto_s & ~frz_s & (prescale == PS_LAST);

  // A manual step restarts the auto interval so the next automatic advance
  // lands a full period after the press.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      prescale <= '0;
    end else if (!auto_s || StepPulse) begin
      prescale <= '0;
    end else if (frz_s) begin
      prescale <= prescale;
    end else if (prescale == PS_LAST) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // A coincident press and tick still advance the view only once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Sel     <= 3'd0;
      DispOut <= 16'h0000;
    end else begin
      if ((StepPulse || auto_tick) && !frz_s) begin
        Sel <= (Sel == SEL_LAST) ? 3'd0 : Sel + 3'd1;
      end
      if (!frz_s) begin
        DispOut <= MuxIn;
      end
    end
  end

endmodule

// File: tb/tb_hex_view_sel_ctrl.sv
module tb_hex_view_sel_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        StepBtn;
  logic        AutoEn;
  logic        Freeze;
  logic [15:0] MuxIn;
  logic [2:0]  Sel;
  logic [15:0] DispOut;
  logic        StepPulse;

  hex_view_sel_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD(10),
    .NUM_VIEWS(8)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .StepBtn(StepBtn),
    .AutoEn(AutoEn),
    .Freeze(Freeze),
    .MuxIn(MuxIn),
    .Sel(Sel),
    .DispOut(DispOut),
    .StepPulse(StepPulse)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  int pulse_total = 0;

  always @(negedge Clock) if (StepPulse) pulse_total++;

  typedef struct {
    logic        btn;
    logic        auto_en;
    logic        frz;
    logic [15:0] mux;
    int          cycles;
    logic [2:0]  sel;
    logic [15:0] disp;
    int          pulses;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic b, input logic a, input logic f, input logic [15:0] m,
                     input int n, input logic [2:0] s, input logic [15:0] d, input int p);
    vec_t v;
    v.btn = b; v.auto_en = a; v.frz = f; v.mux = m;
    v.cycles = n; v.sel = s; v.disp = d; v.pulses = p;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
  endtask

  task automatic do_press();
    StepBtn = 1'b1;
    cyc(10);
    StepBtn = 1'b0;
    cyc(10);
  endtask

  initial begin
    int p0;
    Reset = 1'b1; StepBtn = 1'b0; AutoEn = 1'b0; Freeze = 1'b0; MuxIn = 16'h0000;
    #3;
    chk("reset_sel", 32'(Sel), 32'd0);
    chk("reset_disp", 32'(DispOut), 32'h0);
    chk("reset_pulse", 32'(StepPulse), 32'd0);
    cyc(2);
    Reset = 1'b0;

    // Clean press, release, bounce, wrap, freeze.
    add(0,0,0,16'h1111, 1, 3'd0,16'h1111,0);
    add(1,0,0,16'h2222,20, 3'd1,16'h2222,1);
    add(0,0,0,16'h2222,10, 3'd1,16'h2222,0);
    add(1,0,0,16'h2222, 2, 3'd1,16'h2222,0);
    add(0,0,0,16'h2222, 2, 3'd1,16'h2222,0);
    add(1,0,0,16'h2222, 2, 3'd1,16'h2222,0);
    add(0,0,0,16'h2222, 2, 3'd1,16'h2222,0);
    add(1,0,0,16'h3333,12, 3'd2,16'h3333,1);
    add(0,0,0,16'h3333,10, 3'd2,16'h3333,0);
    for (int i = 0; i < 7; i++) begin
      add(1,0,0,16'(i),10, 3'((3+i)%8),16'(i),1);
      add(0,0,0,16'(i),10, 3'((3+i)%8),16'(i),0);
    end
    add(0,0,0,16'h1234, 2, 3'd1,16'h1234,0);
    add(0,1,1,16'h1234, 3, 3'd1,16'h1234,0);
    add(1,1,1,16'hBEEF,12, 3'd1,16'h1234,1);
    add(0,1,1,16'hBEEF,25, 3'd1,16'h1234,0);
    add(0,0,0,16'hBEEF, 2, 3'd1,16'h1234,0);
    add(0,0,0,16'hBEEF, 1, 3'd1,16'hBEEF,0);

    foreach (vt[k]) begin
      StepBtn = vt[k].btn; AutoEn = vt[k].auto_en; Freeze = vt[k].frz; MuxIn = vt[k].mux;
      p0 = pulse_total;
      cyc(vt[k].cycles);
      chk($sformatf("vec%0d_sel", k), 32'(Sel), 32'(vt[k].sel));
      chk($sformatf("vec%0d_disp", k), 32'(DispOut), 32'(vt[k].disp));
      chk($sformatf("vec%0d_pulses", k), 32'(pulse_total - p0), 32'(vt[k].pulses));
    end

    // Auto mode: edge numbers are counted from the edge before AutoEn rises.
    do_reset();
    AutoEn = 1'b1;
    cyc(11); chk("auto_e11", 32'(Sel), 32'd0);
    cyc(1);  chk("auto_e12", 32'(Sel), 32'd1);
    cyc(19); chk("auto_e31", 32'(Sel), 32'd2);
    cyc(1);  chk("auto_e32", 32'(Sel), 32'd3);
    StepBtn = 1'b1;
    cyc(7);  chk("press_pre7_pulse", 32'(StepPulse), 32'd1);
             chk("press_pre7_sel_before", 32'(Sel), 32'd3);
    cyc(1);  chk("press_pre7_sel", 32'(Sel), 32'd4);
    cyc(2);  chk("no_early_tick", 32'(Sel), 32'd4);
    StepBtn = 1'b0;
    cyc(7);  chk("restart_e49", 32'(Sel), 32'd4);
    cyc(1);  chk("restart_e50", 32'(Sel), 32'd5);
    cyc(2);
    StepBtn = 1'b1;
    cyc(7);  chk("coinc_pulse", 32'(StepPulse), 32'd1);
    cyc(1);  chk("coinc_sel", 32'(Sel), 32'd6);
    cyc(1);  chk("coinc_single", 32'(Sel), 32'd6);
    StepBtn = 1'b0;
    cyc(9);  chk("auto_e70", 32'(Sel), 32'd7);
    AutoEn = 1'b0;

    // Reach Sel=5, then reset asynchronously in the middle of a press.
    for (int i = 0; i < 6; i++) do_press();
    MuxIn = 16'hABCD;
    cyc(2);
    chk("pre_rst_sel", 32'(Sel), 32'd5);
    chk("pre_rst_disp", 32'(DispOut), 32'hABCD);
    StepBtn = 1'b1;
    cyc(4);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_sel", 32'(Sel), 32'd0);
    chk("async_rst_disp", 32'(DispOut), 32'h0);
    chk("async_rst_pulse", 32'(StepPulse), 32'd0);
    cyc(2);
    Reset = 1'b0;
    p0 = pulse_total;
    cyc(6);
    chk("post_rst_no_pulse", 32'(pulse_total - p0), 32'd0);
    chk("post_rst_sel0", 32'(Sel), 32'd0);
    cyc(1);  chk("post_rst_pulse", 32'(StepPulse), 32'd1);
    cyc(1);  chk("post_rst_sel1", 32'(Sel), 32'd1);
    chk("post_rst_one_pulse", 32'(pulse_total - p0), 32'd1);
    StepBtn = 1'b0;
    cyc(10);
    chk("post_rst_release", 32'(pulse_total - p0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
